// File: rtl/pipe_ctrl_if.sv
// Controller <-> pipeline bundle: stall/exception requests in, stall vector, flush/redirect and debug counters out.
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, stall_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, stall_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: prioritised stall vector plus exception flush/redirect, zero-cycle combinational path.
// Counters/watchdog update one edge after the qualifying cycle; the cycle after a flush ignores all requests.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [15:0] WDOG_LIMIT = 16'd1023
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [31:0] ERET_CODE = 32'h0000_000e;

  typedef enum logic {RUN, FLUSHED} state_t;

  state_t      r_state;
  logic [15:0] r_wdog_cnt;
  logic        r_stall_timeout;
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  logic [5:0]  w_stall;
  logic        w_flush;
  logic [31:0] w_new_pc;
  logic        w_active;
  logic [15:0] w_wdog_next;

  // Requests arriving in FLUSHED come from stages that were just squashed.
  assign w_active = !rst && (r_state == RUN);

  always_comb begin
    w_stall  = 6'b000000;
    w_flush  = 1'b0;
    w_new_pc = 32'h0;
    if (w_active) begin
      if (bus.excepttype_i != 32'h0) begin
        w_flush  = 1'b1;
        w_new_pc = (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
      end else if (bus.stallreq_mem) begin
        w_stall = 6'b011111;
      end else if (bus.stallreq_ex) begin
        w_stall = 6'b001111;
      end else if (bus.stallreq_id) begin
        w_stall = 6'b000111;
      end
    end
  end

  assign w_wdog_next = r_wdog_cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= RUN;
      r_wdog_cnt      <= 16'd0;
      r_stall_timeout <= 1'b0;
      r_stall_cycles  <= 32'd0;
      r_flush_count   <= 16'd0;
    end else begin
      case (r_state)
        RUN:     r_state <= w_flush ? FLUSHED : RUN;
        FLUSHED: r_state <= RUN;
        default: r_state <= RUN;
      endcase

      if (w_flush || (w_stall == 6'b000000)) begin
        r_wdog_cnt <= 16'd0;
      end else begin
        r_wdog_cnt <= w_wdog_next;
        // Flag rises on the same edge the count reaches the limit.
        if (w_wdog_next == WDOG_LIMIT) begin
          r_stall_timeout <= 1'b1;
        end
      end

      if (w_stall != 6'b000000) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_flush) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign bus.stall         = w_stall;
  assign bus.flush         = w_flush;
  assign bus.new_pc        = w_new_pc;
  assign bus.stall_timeout = r_stall_timeout;
  assign bus.stall_cycles  = r_stall_cycles;
  assign bus.flush_count   = r_flush_count;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, exception/eret flush, FLUSHED masking, watchdog, reset mid-flush.
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .EXC_VECTOR(32'h0000_0020),
    .WDOG_LIMIT(16'd1023)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    bus.stallreq_id  = 1'b0;
    bus.stallreq_ex  = 1'b0;
    bus.stallreq_mem = 1'b0;
    bus.excepttype_i = 32'h0;
    bus.cp0_epc_i    = 32'h0;
    tick();
    tick();

    // Reset values, and requests ignored while in reset
    chk("rst_stall", {26'h0, bus.stall}, 32'h0);
    chk("rst_flush", {31'h0, bus.flush}, 32'h0);
    chk("rst_new_pc", bus.new_pc, 32'h0);
    chk("rst_timeout", {31'h0, bus.stall_timeout}, 32'h0);
    chk("rst_stall_cycles", bus.stall_cycles, 32'h0);
    chk("rst_flush_count", {16'h0, bus.flush_count}, 32'h0);
    bus.stallreq_mem = 1'b1;
    bus.excepttype_i = 32'h1;
    #1;
    chk("rst_ignore_stall", {26'h0, bus.stall}, 32'h0);
    chk("rst_ignore_flush", {31'h0, bus.flush}, 32'h0);
    tick();
    chk("rst_cnt_hold", {16'h0, bus.flush_count}, 32'h0);
    bus.stallreq_mem = 1'b0;
    bus.excepttype_i = 32'h0;
    rst = 1'b0;

    // ID stall for two cycles
    bus.stallreq_id = 1'b1;
    #1;
    chk("id_stall_c0", {26'h0, bus.stall}, 32'h07);
    tick();
    chk("id_stall_c1", {26'h0, bus.stall}, 32'h07);
    tick();
    bus.stallreq_id = 1'b0;
    #1;
    chk("id_stall_off", {26'h0, bus.stall}, 32'h0);
    chk("id_stall_cycles", bus.stall_cycles, 32'd2);

    // Stall priority
    bus.stallreq_id  = 1'b1;
    bus.stallreq_ex  = 1'b1;
    bus.stallreq_mem = 1'b1;
    #1;
    chk("prio_mem", {26'h0, bus.stall}, 32'h1f);
    bus.stallreq_mem = 1'b0;
    #1;
    chk("prio_ex", {26'h0, bus.stall}, 32'h0f);
    bus.stallreq_ex = 1'b0;
    #1;
    chk("prio_id", {26'h0, bus.stall}, 32'h07);
    bus.stallreq_id = 1'b0;
    #1;
    chk("prio_none", {26'h0, bus.stall}, 32'h0);
    tick();

    // Exception together with a MEM stall
    bus.stallreq_mem = 1'b1;
    bus.excepttype_i = 32'h1;
    #1;
    chk("exc_flush", {31'h0, bus.flush}, 32'h1);
    chk("exc_stall", {26'h0, bus.stall}, 32'h0);
    chk("exc_new_pc", bus.new_pc, 32'h20);
    tick();
    chk("flushed_flush", {31'h0, bus.flush}, 32'h0);
    chk("flushed_stall", {26'h0, bus.stall}, 32'h0);
    chk("flushed_new_pc", bus.new_pc, 32'h0);
    chk("exc_flush_count", {16'h0, bus.flush_count}, 32'd1);
    chk("exc_no_stall_count", bus.stall_cycles, 32'd2);
    bus.stallreq_mem = 1'b0;
    bus.excepttype_i = 32'h0;
    tick();
    chk("flushed_no_stall_count", bus.stall_cycles, 32'd2);

    // eret redirect
    bus.excepttype_i = 32'h0000_000e;
    bus.cp0_epc_i    = 32'h0000_1234;
    #1;
    chk("eret_flush", {31'h0, bus.flush}, 32'h1);
    chk("eret_new_pc", bus.new_pc, 32'h0000_1234);
    tick();
    chk("eret_flushed_flush", {31'h0, bus.flush}, 32'h0);
    chk("eret_flush_count", {16'h0, bus.flush_count}, 32'd2);
    bus.excepttype_i = 32'h0;
    tick();

    // Watchdog
    bus.stallreq_ex = 1'b1;
    for (int i = 0; i < 1022; i++) tick();
    chk("wdog_1022", {31'h0, bus.stall_timeout}, 32'h0);
    tick();
    chk("wdog_1023", {31'h0, bus.stall_timeout}, 32'h1);
    chk("wdog_stall_cycles", bus.stall_cycles, 32'd1025);
    bus.stallreq_ex = 1'b0;
    tick();
    tick();
    chk("wdog_sticky", {31'h0, bus.stall_timeout}, 32'h1);

    // Reset pulsed during FLUSHED
    bus.excepttype_i = 32'h3;
    #1;
    chk("rmf_flush", {31'h0, bus.flush}, 32'h1);
    tick();
    chk("rmf_flush_count", {16'h0, bus.flush_count}, 32'd3);
    rst = 1'b1;
    #1;
    chk("rmf_rst_flush", {31'h0, bus.flush}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("rmf_timeout", {31'h0, bus.stall_timeout}, 32'h0);
    chk("rmf_stall_cycles", bus.stall_cycles, 32'h0);
    chk("rmf_flush_count0", {16'h0, bus.flush_count}, 32'h0);
    chk("rmf_new_flush", {31'h0, bus.flush}, 32'h1);
    chk("rmf_new_pc", bus.new_pc, 32'h20);
    tick();
    chk("rmf_flush_count1", {16'h0, bus.flush_count}, 32'd1);
    chk("rmf_no_back_to_back", {31'h0, bus.flush}, 32'h0);
    bus.excepttype_i = 32'h0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the five-stage CPU. It merges stall requests from ID, EX and MEM into the 6-bit `stall` vector, which every pipeline register (pc, if/id, id/ex, ex/mem, mem/wb) consumes. It also turns exception and `eret` events from MEM into a pipeline flush plus redirect PC. It keeps a stall watchdog and performance counters for debug.

## Interface
- `EXC_VECTOR`, 32'h0000_0020: redirect target for every exception except `eret`.
- `WDOG_LIMIT`, 16'd1023: number of consecutive stalled cycles that sets `stall_timeout`.
- `clk` input 1: pipeline clock, all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `stallreq_id` input 1: ID needs a bubble (load-use hazard).
- `stallreq_ex` input 1: EX multi-cycle operation is busy (div/madd).
- `stallreq_mem` input 1: MEM data bus is not ready.
- `excepttype_i` input 32: exception code from MEM; 0 means none; 32'h0000_000e means `eret`.
- `cp0_epc_i` input 32: current EPC from CP0.
- `stall` output 6: bit0 pc, bit1 if/id, bit2 id/ex, bit3 ex/mem, bit4 mem/wb, bit5 wb.
- `flush` output 1: clear all pipeline registers this cycle.
- `new_pc` output 32: PC redirect target, valid while `flush`=1.
- `stall_timeout` output 1: sticky watchdog flag.
- `stall_cycles` output 32: count of cycles with `stall`≠0.
- `flush_count` output 16: count of flushes.

## Operation
- `stall`, `flush` and `new_pc` are combinational, so a request stops the pipeline in the same cycle. The counters and the FSM are registered.
- Priority, highest first:
  - exception: `excepttype_i`≠0 → `flush`=1, `stall`=0.
  - `stallreq_mem` → `stall`=6'b011111.
  - `stallreq_ex` → `stall`=6'b001111.
  - `stallreq_id` → `stall`=6'b000111.
  - none → `stall`=0.
- Stages upstream of the highest stalled stage hold their value. The first unstalled stage downstream inserts a bubble; this matches the if/id rule "stall[n] && !stall[n+1] → zero".
- `new_pc` is `cp0_epc_i` when `excepttype_i`=32'h0e. It is `EXC_VECTOR` for any other nonzero code. It is 0 when there is no exception.
- FSM states:
  - RUN: default state. On an exception, go to FLUSHED.
  - FLUSHED: lasts exactly one cycle, then returns to RUN. In this state the controller forces `flush`=0 and `stall`=0 and ignores all requests, including a new `excepttype_i`, because they come from already-flushed stages.
  - Watchdog: a 16-bit `wdog_cnt` increments on each cycle with `stall`≠0 and clears on any cycle with `stall`=0 or `flush`=1. When `wdog_cnt` reaches `WDOG_LIMIT`, `stall_timeout` sets and stays set until `rst`.
- Counters:
  - `stall_cycles` increments on each cycle with `stall`≠0 and wraps modulo 2^32.
  - `flush_count` increments on each `flush` cycle and wraps modulo 2^16.

## Timing
- Values while `rst`=1 and after it:
  - state = RUN.
  - `stall` = 0, `flush` = 0, `new_pc` = 0.
  - `stall_timeout` = 0, `stall_cycles` = 0, `flush_count` = 0, `wdog_cnt` = 0.
  - Requests are ignored while `rst`=1.
- Latency from request to `stall` is 0 cycles (combinational). The request is honoured at the same rising edge.
- `flush` is high for exactly one cycle per exception. It is never high in two consecutive cycles.
- A stall request and an exception arriving together give `flush` only. No stall is counted that cycle.
- Reset asserted while in FLUSHED returns to RUN at the next edge, and all counters clear.
- Counter updates are visible one cycle after the qualifying cycle.

## Test plan
- **ID stall:** `stallreq_id`=1 for 2 cycles → `stall`=6'b000111 in both cycles, then 0. `stall_cycles` reads 2 one cycle later.
- **Stall priority:** `stallreq_id`, `stallreq_ex` and `stallreq_mem` all 1 → `stall`=6'b011111. Drop `stallreq_mem` → `stall`=6'b001111.
- **Exception while stalled:** `excepttype_i`=32'h1 together with `stallreq_mem`=1 → `flush`=1, `stall`=0, `new_pc`=32'h20. Next cycle, `excepttype_i` still 1 → `flush`=0, because the FSM is in FLUSHED. `flush_count`=1.
- **eret redirect:** `excepttype_i`=32'h0e with `cp0_epc_i`=32'h0000_1234 → `new_pc`=32'h0000_1234 with `flush`=1.
- **Watchdog:** `stallreq_ex` held for 1023 cycles → `stall_timeout` rises after the 1023rd stalled cycle. It stays 1 after the request drops and clears only on `rst`.
- **Reset mid-flush:** `rst` pulsed during FLUSHED → all outputs and counters are 0. A new exception on the following cycle flushes normally.
